// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: ALU op codes, exec FSM state encoding and shift-class helper shared by the decoder and execute unit
package alu_ctrl_pkg;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_XOR = 4'b1100;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;
  function automatic logic is_shift(input logic [3:0] c);
    return c == ALU_SLL || c == ALU_SRL || c == ALU_SRA;
  endfunction
endpackage

// File: rtl/alu_comb.sv
// alu_comb: single-cycle AND/OR/ADD/SUB/SLT/XOR datapath (ports: alu_ctrl_i, op_a_i, op_b_i -> res_o), zero for other codes
module alu_comb
  import alu_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]      alu_ctrl_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  output logic [XLEN-1:0] res_o
);
  logic lt;
  always_comb begin
    lt = $signed(op_a_i) < $signed(op_b_i);
    res_o = alu_ctrl_i == ALU_AND ? op_a_i & op_b_i :
            alu_ctrl_i == ALU_OR  ? op_a_i | op_b_i :
            alu_ctrl_i == ALU_ADD ? op_a_i + op_b_i :
            alu_ctrl_i == ALU_SUB ? op_a_i - op_b_i :
            alu_ctrl_i == ALU_SLT ? {{(XLEN-1){1'b0}}, lt} :
            alu_ctrl_i == ALU_XOR ? op_a_i ^ op_b_i : '0;
  end
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with iterative 1-bit/cycle shifter (in_valid/in_ready/alu_ctrl/op_a/op_b in, out_valid/out_ready/result/zero out)
module alu_exec_unit
  import alu_ctrl_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);
  state_e              state_q;
  logic [3:0]          op_q;
  logic [XLEN-1:0]     sh_q, result_q, comb_res, first_d, sh_d;
  logic [SHAMT_W-1:0]  cnt_q, shamt;
  function automatic logic [XLEN-1:0] shift1(input logic [3:0] c, input logic [XLEN-1:0] v);
    return c == ALU_SLL ? v << 1 : c == ALU_SRL ? v >> 1 : {v[XLEN-1], v[XLEN-1:1]};
  endfunction
  alu_comb #(.XLEN(XLEN)) u_comb (
    .alu_ctrl_i(alu_ctrl),
    .op_a_i    (op_a),
    .op_b_i    (op_b),
    .res_o     (comb_res)
  );
  // the first bit is shifted on the accept edge so an n-bit shift presents its result n cycles after accept
  always_comb begin
    shamt   = op_b[SHAMT_W-1:0];
    first_d = shift1(alu_ctrl, op_a);
    sh_d    = shift1(op_q, sh_q);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= ALU_AND;
      sh_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) begin
          if (!is_shift(alu_ctrl)) begin
            result_q <= comb_res;
            state_q  <= S_DONE;
          end else if (shamt == '0) begin
            result_q <= op_a;
            state_q  <= S_DONE;
          end else if (shamt == SHAMT_W'(1)) begin
            result_q <= first_d;
            state_q  <= S_DONE;
          end else begin
            op_q    <= alu_ctrl;
            sh_q    <= first_d;
            cnt_q   <= shamt - SHAMT_W'(1);
            state_q <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          sh_q  <= sh_d;
          cnt_q <= cnt_q - SHAMT_W'(1);
          if (cnt_q == SHAMT_W'(1)) begin
            result_q <= sh_d;
            state_q  <= S_DONE;
          end
        end
        S_DONE: if (out_ready) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign in_ready  = state_q == S_IDLE;
  assign out_valid = state_q == S_DONE;
  assign result    = result_q;
  assign zero      = result_q == '0;
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed self-checking bench for alu_exec_unit
module tb_alu_exec_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  alu_ctrl = 4'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        zero;
  int          total = 0;
  int          bad = 0;
  int          cyc;
  always #5 clk = ~clk;
  alu_exec_unit dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .alu_ctrl (alu_ctrl),
    .op_a     (op_a),
    .op_b     (op_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .zero     (zero)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    alu_ctrl = c;
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    op_a     = 32'h5555_AAAA;
    op_b     = 32'hAAAA_5555;
    cyc      = 1;
    while (!out_valid && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
  endtask
  task automatic op(input string tag, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] exp, input int lat);
    out_ready = 1'b1;
    issue(c, a, b);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_lat"}, 32'(cyc), 32'(lat));
    chk({tag, "_res"}, result, exp);
    chk({tag, "_zero"}, 32'(zero), 32'(exp == 0));
    chk({tag, "_rdy_busy"}, 32'(in_ready), 32'd0);
    @(negedge clk);
    chk({tag, "_rdy_back"}, 32'(in_ready), 32'd1);
    chk({tag, "_vld_drop"}, 32'(out_valid), 32'd0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", 32'(zero), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    op("add", 4'b0010, 32'd5, 32'd7, 32'd12, 1);
    op("sub_eq", 4'b0110, 32'd7, 32'd7, 32'd0, 1);
    op("sub_wrap", 4'b0110, 32'd0, 32'd1, 32'hFFFF_FFFF, 1);
    op("bad_code", 4'b1111, 32'h1234, 32'h5678, 32'd0, 1);
    op("slt_neg", 4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd1, 1);
    op("slt_pos", 4'b0111, 32'd1, 32'hFFFF_FFFF, 32'd0, 1);
    op("and", 4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1);
    op("or", 4'b0001, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 1);
    op("xor", 4'b1100, 32'hA5A5_A5A5, 32'hFFFF_0000, 32'h5A5A_A5A5, 1);
    op("sra4", 4'b1010, 32'h8000_0000, 32'h24, 32'hF800_0000, 4);
    op("srl4", 4'b1001, 32'h8000_0000, 32'h24, 32'h0800_0000, 4);
    op("sra_pos", 4'b1010, 32'h7FFF_FFF0, 32'h4, 32'h07FF_FFFF, 4);
    op("sll0", 4'b1000, 32'hDEAD_BEEF, 32'h20, 32'hDEAD_BEEF, 1);
    op("sll1", 4'b1000, 32'h4000_0001, 32'h1, 32'h8000_0002, 1);
    op("srl31", 4'b1001, 32'hFFFF_FFFF, 32'h1F, 32'h1, 31);
    out_ready = 1'b0;
    issue(4'b0010, 32'd10, 32'd20);
    chk("bp_lat", 32'(cyc), 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_result", result, 32'd30);
      chk("bp_zero", 32'(zero), 32'd0);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      in_valid = (i == 1);
      alu_ctrl = 4'b0110;
      op_a     = 32'd3;
      op_b     = 32'd3;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("bp_hold_result", result, 32'd30);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    chk("bp_no_stray", result, 32'd30);
    op("bp_next", 4'b1100, 32'h0000_FFFF, 32'h0000_0F0F, 32'h0000_F0F0, 1);
    alu_ctrl = 4'b1000;
    op_a     = 32'd1;
    op_b     = 32'd31;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("mid_busy_valid", 32'(out_valid), 32'd0);
    chk("mid_busy_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_result", result, 32'd0);
    chk("mid_rst_zero", 32'(zero), 32'd1);
    op("post_rst_add", 4'b0010, 32'd2, 32'd3, 32'd5, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
